hps_adc_sample_fifo: RTL and testbench

Parametrised, multi-channel successor to the single-register ADC input port on the HPS lightweight bus. It captures tagged ADC samples from the converter front end into a FIFO, with a per-channel enable mask. It exposes an Avalon-MM slave with registered, read-latency-1 readdata for HPS polling or interrupt-driven draining. Overflow is tracked by a sticky flag and a level-threshold interrupt.

---
 rtl/hps_adc_sample_fifo_if.sv | 30 +++
 rtl/hps_adc_sample_fifo.sv | 142 ++++++++++++++
 tb/tb_hps_adc_sample_fifo.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hps_adc_sample_fifo_if.sv
// Sample-capture and Avalon-MM register-bus signals for hps_adc_sample_fifo.
// The master side drives ADC samples and bus requests; the slave side returns readdata and irq.
interface hps_adc_sample_fifo_if #(
   parameter int DATA_W   = 12,
   parameter int CHANNELS = 8
);
   localparam int CH_W = $clog2(CHANNELS);

   logic              sample_valid;
   logic [DATA_W-1:0] sample_data;
   logic [CH_W-1:0]   sample_chan;
   logic [1:0]        address;
   logic              read;
   logic              write;
   logic [31:0]       writedata;
   logic [31:0]       readdata;
   logic              irq;

   modport master (
      output sample_valid, sample_data, sample_chan,
      output address, read, write, writedata,
      input  readdata, irq
   );

   modport slave (
      input  sample_valid, sample_data, sample_chan,
      input  address, read, write, writedata,
      output readdata, irq
   );
endinterface

// File: rtl/hps_adc_sample_fifo.sv
// Multi-channel tagged ADC sample FIFO with an Avalon-MM slave (read latency 1),
// per-channel capture mask, sticky overflow and a level-threshold interrupt.
module hps_adc_sample_fifo #(
   parameter int DATA_W   = 12,
   parameter int CHANNELS = 8,
   parameter int DEPTH    = 16
) (
   input logic                   clk,
   input logic                   reset,
   hps_adc_sample_fifo_if.slave  bus
);
   localparam int CH_W  = $clog2(CHANNELS);
   localparam int LVL_W = $clog2(DEPTH) + 1;
   localparam int PTR_W = LVL_W - 1;
   localparam int ENT_W = CH_W + DATA_W;

   logic [ENT_W-1:0]    mem_q [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]    level_q, level_d;
   logic                ovf_q, ovf_d;
   logic                en_q, en_d;
   logic                ien_q, ien_d;
   logic [7:0]          thr_q, thr_d;
   logic [CHANNELS-1:0] mask_q, mask_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                irq_q, irq_d;

   logic             empty, full, chan_ok, push_req, push, pop, flush;
   logic             wr_status, wr_ctrl, wr_mask;
   logic [ENT_W-1:0] head;

   assign empty     = (level_q == '0);
   assign full      = (level_q == LVL_W'(DEPTH));
   assign head      = mem_q[rd_ptr_q];
   assign chan_ok   = ({{(32-CH_W){1'b0}}, bus.sample_chan} < 32'(CHANNELS));
   assign push_req  = bus.sample_valid & en_q & chan_ok & mask_q[bus.sample_chan];
   assign wr_status = bus.write & (bus.address == 2'd1);
   assign wr_ctrl   = bus.write & (bus.address == 2'd2);
   assign wr_mask   = bus.write & (bus.address == 2'd3);
   assign flush     = wr_ctrl & bus.writedata[2];
   assign pop       = bus.read & (bus.address == 2'd0) & ~empty;
   // A push into a full FIFO only succeeds when a pop frees the slot in the same cycle.
   assign push      = push_req & (~full | pop) & ~flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q;
      en_d     = en_q;
      ien_d    = ien_q;
      thr_d    = thr_q;
      mask_d   = mask_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
      end

      // Set beats a same-cycle software clear.
      if (push_req & full & ~pop & ~flush) ovf_d = 1'b1;
      else if (wr_status & bus.writedata[18]) ovf_d = 1'b0;

      if (wr_ctrl) begin
         en_d  = bus.writedata[0];
         ien_d = bus.writedata[1];
         thr_d = bus.writedata[15:8];
      end
      if (wr_mask) mask_d = bus.writedata[CHANNELS-1:0];
   end

   always_comb begin
      rdata_d = '0;
      case (bus.address)
         2'd0: if (!empty) begin
            rdata_d[31]             = 1'b1;
            rdata_d[16 +: CH_W]     = head[DATA_W +: CH_W];
            rdata_d[DATA_W-1:0]     = head[DATA_W-1:0];
         end
         2'd1: begin
            rdata_d[LVL_W-1:0] = level_q;
            rdata_d[16]        = empty;
            rdata_d[17]        = full;
            rdata_d[18]        = ovf_q;
         end
         2'd2: begin
            rdata_d[0]    = en_q;
            rdata_d[1]    = ien_q;
            rdata_d[15:8] = thr_q;
         end
         default: rdata_d[CHANNELS-1:0] = mask_q;
      endcase
   end

   always_comb begin
      irq_d = ien_q & (((thr_q != 8'd0) & (16'(level_q) >= 16'(thr_q))) | ovf_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         en_q     <= 1'b0;
         ien_q    <= 1'b0;
         thr_q    <= '0;
         mask_q   <= '1;
         rdata_q  <= '0;
         irq_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         en_q     <= en_d;
         ien_q    <= ien_d;
         thr_q    <= thr_d;
         mask_q   <= mask_d;
         rdata_q  <= rdata_d;
         irq_q    <= irq_d;
      end
   end

   // Storage needs no reset: level and pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {bus.sample_chan, bus.sample_data};
   end

   assign bus.readdata = rdata_q;
   assign bus.irq      = irq_q;
endmodule

// File: tb/tb_hps_adc_sample_fifo.sv
// Self-checking bench for hps_adc_sample_fifo: directed scenarios plus randomized
// traffic checked against a queue-based register/FIFO model.
module tb_hps_adc_sample_fifo;
   localparam int DATA_W   = 12;
   localparam int CHANNELS = 8;
   localparam int DEPTH    = 16;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   errors = 0;
   int   checks = 0;

   hps_adc_sample_fifo_if #(.DATA_W(DATA_W), .CHANNELS(CHANNELS)) bus ();

   hps_adc_sample_fifo #(.DATA_W(DATA_W), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: queue of expected DATA words plus register shadows.
   logic [31:0] mq [$];
   logic        m_ovf, m_en, m_ien;
   logic [7:0]  m_thr, m_mask;

   task automatic model_reset();
      mq.delete();
      m_ovf = 1'b0; m_en = 1'b0; m_ien = 1'b0; m_thr = 8'd0; m_mask = 8'hFF;
   endtask

   task automatic idle_inputs();
      bus.sample_valid = 1'b0; bus.sample_data = '0; bus.sample_chan = '0;
      bus.address = 2'd0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // One bus/sample cycle: predicts readdata and irq seen after the edge, then advances the model.
   task automatic step(input logic v, input logic [2:0] ch, input logic [11:0] d,
                       input logic rd, input logic wr, input logic [1:0] a, input logic [31:0] wd,
                       output logic [31:0] e_rd, output logic e_irq);
      int  sz;
      bit  do_pop, do_flush, preq, ovf_set;
      sz = mq.size();
      bus.sample_valid = v; bus.sample_chan = ch; bus.sample_data = d;
      bus.read = rd; bus.write = wr; bus.address = a; bus.writedata = wd;

      e_rd = '0;
      case (a)
         2'd0: if (sz > 0) e_rd = mq[0];
         2'd1: begin
            e_rd[4:0] = 5'(sz);
            e_rd[16]  = (sz == 0);
            e_rd[17]  = (sz == DEPTH);
            e_rd[18]  = m_ovf;
         end
         2'd2: e_rd = {16'h0, m_thr, 6'b0, m_ien, m_en};
         default: e_rd = {24'h0, m_mask};
      endcase
      e_irq = m_ien && (((m_thr != 0) && (sz >= int'(m_thr))) || m_ovf);

      do_pop   = rd && (a == 2'd0) && (sz > 0);
      do_flush = wr && (a == 2'd2) && wd[2];
      preq     = v && m_en && m_mask[ch];
      ovf_set  = 1'b0;
      if (do_flush) mq.delete();
      else begin
         if (do_pop) void'(mq.pop_front());
         if (preq) begin
            if (sz < DEPTH || do_pop) mq.push_back(32'h8000_0000 | (32'(ch) << 16) | 32'(d));
            else ovf_set = 1'b1;
         end
      end
      if (ovf_set) m_ovf = 1'b1;
      else if (wr && a == 2'd1 && wd[18]) m_ovf = 1'b0;
      if (wr && a == 2'd2) begin m_en = wd[0]; m_ien = wd[1]; m_thr = wd[15:8]; end
      if (wr && a == 2'd3) m_mask = wd[7:0];

      @(posedge clk);
      #1 idle_inputs();
   endtask

   task automatic test_reset();
      logic [31:0] e; logic ei;
      do_reset();
      if (bus.readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata got=%h exp=%h", bus.readdata, 32'h0); end
      checks++;
      if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", bus.irq); end
      checks++;
      step(0, 0, 0, 1, 0, 2'd1, 0, e, ei);
      if (bus.readdata !== 32'h0001_0000) begin errors++; $display("FAIL reset_status got=%h exp=%h", bus.readdata, 32'h0001_0000); end
      checks++;
      step(0, 0, 0, 1, 0, 2'd2, 0, e, ei);
      if (bus.readdata !== 32'h0) begin errors++; $display("FAIL reset_ctrl got=%h exp=%h", bus.readdata, 32'h0); end
      checks++;
      step(0, 0, 0, 1, 0, 2'd3, 0, e, ei);
      if (bus.readdata !== 32'hFF) begin errors++; $display("FAIL reset_chmask got=%h exp=%h", bus.readdata, 32'hFF); end
      checks++;
   endtask

   task automatic test_single();
      logic [31:0] e; logic ei;
      step(0, 0, 0, 0, 1, 2'd2, 32'h1, e, ei);
      step(1, 3'd3, 12'hABC, 0, 0, 2'd0, 0, e, ei);
      step(0, 0, 0, 1, 0, 2'd1, 0, e, ei);
      if (bus.readdata !== 32'h0000_0001) begin errors++; $display("FAIL single_level1 got=%h exp=%h", bus.readdata, 32'h1); end
      checks++;
      step(0, 0, 0, 1, 0, 2'd0, 0, e, ei);
      if (bus.readdata !== 32'h8003_0ABC) begin errors++; $display("FAIL single_pop got=%h exp=%h", bus.readdata, 32'h8003_0ABC); end
      checks++;
      step(0, 0, 0, 1, 0, 2'd0, 0, e, ei);
      if (bus.readdata !== 32'h0) begin errors++; $display("FAIL single_empty_pop got=%h exp=%h", bus.readdata, 32'h0); end
      checks++;
      step(0, 0, 0, 1, 0, 2'd1, 0, e, ei);
      if (bus.readdata !== 32'h0001_0000) begin errors++; $display("FAIL single_level0 got=%h exp=%h", bus.readdata, 32'h0001_0000); end
      checks++;
   endtask

   task automatic test_overflow();
      logic [31:0] e; logic ei;
      for (int i = 0; i < DEPTH + 1; i++)
         step(1, 3'($urandom_range(0, 7)), 12'($urandom), 0, 0, 2'd0, 0, e, ei);
      step(0, 0, 0, 1, 0, 2'd1, 0, e, ei);
      if (bus.readdata !== 32'h0006_0010) begin errors++; $display("FAIL ovf_status got=%h exp=%h", bus.readdata, 32'h0006_0010); end
      checks++;
      for (int i = 0; i < DEPTH; i++) begin
         step(0, 0, 0, 1, 0, 2'd0, 0, e, ei);
         if (bus.readdata !== e) begin errors++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, bus.readdata, e); end
         checks++;
      end
      step(0, 0, 0, 0, 1, 2'd1, 32'h0004_0000, e, ei);
      step(0, 0, 0, 1, 0, 2'd1, 0, e, ei);
      if (bus.readdata !== 32'h0001_0000) begin errors++; $display("FAIL ovf_clear got=%h exp=%h", bus.readdata, 32'h0001_0000); end
      checks++;
   endtask

   task automatic test_mask();
      logic [31:0] e; logic ei;
      logic [31:0] nine;
      nine = 32'd9;
      step(0, 0, 0, 0, 1, 2'd3, 32'h1, e, ei);
      step(1, 3'd0, 12'h111, 0, 0, 2'd0, 0, e, ei);
      step(1, 3'd1, 12'h222, 0, 0, 2'd0, 0, e, ei);
      step(1, nine[2:0], 12'h333, 0, 0, 2'd0, 0, e, ei);
      step(0, 0, 0, 1, 0, 2'd1, 0, e, ei);
      if (bus.readdata !== 32'h0000_0001) begin errors++; $display("FAIL mask_level got=%h exp=%h", bus.readdata, 32'h1); end
      checks++;
      step(0, 0, 0, 1, 0, 2'd0, 0, e, ei);
      if (bus.readdata !== 32'h8000_0111) begin errors++; $display("FAIL mask_data got=%h exp=%h", bus.readdata, 32'h8000_0111); end
      checks++;
      step(0, 0, 0, 0, 1, 2'd3, 32'hFF, e, ei);
   endtask

   task automatic test_irq();
      logic [31:0] e; logic ei;
      step(0, 0, 0, 0, 1, 2'd2, 32'h0403, e, ei);
      for (int i = 0; i < 3; i++) step(1, 3'(i), 12'(i), 0, 0, 2'd0, 0, e, ei);
      step(0, 0, 0, 0, 0, 2'd0, 0, e, ei);
      if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_below got=%b exp=0", bus.irq); end
      checks++;
      step(1, 3'd4, 12'h4, 0, 0, 2'd0, 0, e, ei);
      if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_latency got=%b exp=0", bus.irq); end
      checks++;
      step(0, 0, 0, 0, 0, 2'd0, 0, e, ei);
      if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_raise got=%b exp=1", bus.irq); end
      checks++;
      step(0, 0, 0, 1, 0, 2'd0, 0, e, ei);
      step(0, 0, 0, 0, 0, 2'd0, 0, e, ei);
      if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_drop got=%b exp=0", bus.irq); end
      checks++;
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 2'd0, 0, e, ei);
      step(0, 0, 0, 0, 1, 2'd2, 32'h1, e, ei);
   endtask

   task automatic test_full_simul_and_async_reset();
      logic [31:0] e; logic ei;
      step(0, 0, 0, 0, 1, 2'd2, 32'h1003, e, ei);
      for (int i = 0; i < DEPTH; i++) step(1, 3'($urandom_range(0, 7)), 12'($urandom), 0, 0, 2'd0, 0, e, ei);
      step(1, 3'd5, 12'h5A5, 1, 0, 2'd0, 0, e, ei);
      if (bus.readdata !== e) begin errors++; $display("FAIL full_simul_data got=%h exp=%h", bus.readdata, e); end
      checks++;
      step(0, 0, 0, 1, 0, 2'd1, 0, e, ei);
      if (bus.readdata !== 32'h0002_0010) begin errors++; $display("FAIL full_simul_status got=%h exp=%h", bus.readdata, 32'h0002_0010); end
      checks++;
      if (bus.irq !== 1'b1) begin errors++; $display("FAIL full_irq got=%b exp=1", bus.irq); end
      checks++;
      bus.sample_valid = 1'b1;
      bus.sample_chan  = 3'd2;
      #2 reset = 1'b1;
      #1;
      if (bus.readdata !== 32'h0) begin errors++; $display("FAIL async_rst_readdata got=%h exp=%h", bus.readdata, 32'h0); end
      checks++;
      if (bus.irq !== 1'b0) begin errors++; $display("FAIL async_rst_irq got=%b exp=0", bus.irq); end
      checks++;
      do_reset();
      step(0, 0, 0, 1, 0, 2'd1, 0, e, ei);
      if (bus.readdata !== 32'h0001_0000) begin errors++; $display("FAIL async_rst_empty got=%h exp=%h", bus.readdata, 32'h0001_0000); end
      checks++;
   endtask

   task automatic test_random();
      logic [31:0] e, wd; logic ei;
      logic [1:0] a;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         a  = 2'($urandom_range(0, 3));
         wd = $urandom;
         if (a == 2'd2) begin
            wd = '0;
            wd[15:8] = 8'($urandom_range(0, 20));
            wd[2] = ($urandom_range(0, 5) == 0);
            wd[1] = 1'($urandom);
            wd[0] = ($urandom_range(0, 3) != 0);
         end else if (a == 2'd3) begin
            wd = 32'($urandom) | 32'hA5;
         end
         step(1'($urandom), 3'($urandom_range(0, 7)), 12'($urandom), ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 7) == 0), a, wd, e, ei);
         if (bus.readdata !== e) begin errors++; $display("FAIL rand_rd%0d got=%h exp=%h", n, bus.readdata, e); end
         checks++;
         if (bus.irq !== ei) begin errors++; $display("FAIL rand_irq%0d got=%b exp=%b", n, bus.irq, ei); end
         checks++;
      end
   endtask

   initial begin
      idle_inputs();
      model_reset();
      test_reset();
      test_single();
      test_overflow();
      test_mask();
      test_irq();
      test_full_simul_and_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
